// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter
//   OAM DMA engine plus memory-bus arbiter between the CPU core and the memory decoder.
//   A CPU write to DMA_REG_ADDR latches a source page and copies DMA_LEN bytes from
//   {src_hi, 8'h00} into OAM, one READ + one WRITE cycle per byte. While a copy runs the
//   engine owns the bus and the CPU only reaches HRAM (FF80..FFFE).
//
// Ports
//   core_clk          in   core clock, rising edge
//   reset             in   synchronous active-high reset
//   cpu_address_bus   in   CPU address
//   cpu_data_bus_out  in   CPU write data
//   cpu_mem_we        in   CPU write strobe
//   cpu_data_bus_in   out  read data returned to the CPU
//   mem_address       out  address to the memory decoder
//   mem_data_out      out  write data to the memory decoder
//   mem_we            out  write strobe to the memory decoder
//   mem_data_in       in   read data from the memory decoder
//   oam_address       out  OAM byte index
//   oam_data          out  OAM write data
//   oam_we            out  OAM write strobe
//   dma_active        out  high while the engine owns the bus
module oam_dma_arbiter #(
    parameter int unsigned DMA_LEN      = 160,
    parameter int unsigned START_DELAY  = 1,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic        core_clk,
    input  logic        reset,
    input  logic [15:0] cpu_address_bus,
    input  logic [7:0]  cpu_data_bus_out,
    input  logic        cpu_mem_we,
    output logic [7:0]  cpu_data_bus_in,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_out,
    output logic        mem_we,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  oam_address,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);
    localparam logic [1:0] START_CNT = 2'(START_DELAY);

    typedef enum logic [1:0] {StIdle, StStart, StRead, StWrite} state_t;

    state_t     state;
    logic [7:0] dma_reg;
    logic [7:0] idx;
    logic [1:0] delay_cnt;
    logic [7:0] rd_buf;

    logic       is_reg;
    logic       is_hram;
    logic       trigger;
    logic [7:0] src_hi;

    assign is_reg  = (cpu_address_bus == DMA_REG_ADDR);
    assign is_hram = (cpu_address_bus >= 16'hFF80) && (cpu_address_bus <= 16'hFFFE);
    assign trigger = cpu_mem_we && is_reg;
    // Pages E0..FF mirror C0..DF (echo RAM), so fold them back down.
    assign src_hi  = (dma_reg < 8'hE0) ? dma_reg : dma_reg - 8'h20;

    always_ff @(posedge core_clk) begin
        if (reset) begin
            state     <= StIdle;
            dma_reg   <= 8'h00;
            idx       <= 8'h00;
            delay_cnt <= 2'd0;
            rd_buf    <= 8'h00;
        end else begin
            if (state == StRead) begin
                rd_buf <= mem_data_in;
            end
            // A trigger restarts from any state; a WRITE in flight still commits this cycle
            // because the OAM strobe is decoded from the current state.
            if (trigger) begin
                dma_reg   <= cpu_data_bus_out;
                idx       <= 8'h00;
                delay_cnt <= START_CNT;
                state     <= (START_DELAY == 0) ? StRead : StStart;
            end else begin
                unique case (state)
                    StIdle: state <= StIdle;
                    StStart: begin
                        delay_cnt <= delay_cnt - 2'd1;
                        if (delay_cnt <= 2'd1) begin
                            state <= StRead;
                        end
                    end
                    StRead: state <= StWrite;
                    StWrite: begin
                        if (idx == LAST_IDX) begin
                            state <= StIdle;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= StRead;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        mem_address     = cpu_address_bus;
        mem_data_out    = cpu_data_bus_out;
        mem_we          = cpu_mem_we && !is_reg;
        cpu_data_bus_in = mem_data_in;
        oam_address     = 8'h00;
        oam_data        = 8'h00;
        oam_we          = 1'b0;

        // CPU is fenced to HRAM while the engine owns the bus.
        if (state != StIdle && !is_hram) begin
            mem_we          = 1'b0;
            cpu_data_bus_in = 8'hFF;
        end
        // The source read owns the shared address, so no write may ride along with it.
        if (state == StRead) begin
            mem_address = {src_hi, idx};
            mem_we      = 1'b0;
        end
        if (state == StWrite) begin
            oam_we      = 1'b1;
            oam_address = idx;
            oam_data    = rd_buf;
        end
        if (is_reg) begin
            cpu_data_bus_in = dma_reg;
        end
    end

    assign dma_active = (state != StIdle);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
module tb_oam_dma_arbiter;

    logic        core_clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_address_bus;
    logic [7:0]  cpu_data_bus_out;
    logic        cpu_mem_we;
    logic [7:0]  cpu_data_bus_in;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_out;
    logic        mem_we;
    logic [7:0]  mem_data_in;
    logic [7:0]  oam_address;
    logic [7:0]  oam_data;
    logic        oam_we;
    logic        dma_active;

    // Second instance: START_DELAY=0, DMA_LEN=1
    logic [15:0] cpu1_address;
    logic [7:0]  cpu1_data;
    logic        cpu1_we;
    logic [7:0]  cpu1_data_bus_in;
    logic [15:0] mem1_address;
    logic [7:0]  mem1_data_out;
    logic        mem1_we;
    logic [7:0]  mem1_data_in;
    logic [7:0]  oam1_address;
    logic [7:0]  oam1_data;
    logic        oam1_we;
    logic        dma1_active;

    logic [7:0]  mem [0:65535];
    logic [15:0] sb [$];
    int          errors = 0;
    int          checks = 0;
    int          active_cnt = 0;

    always #5 core_clk = ~core_clk;

    assign mem_data_in  = mem[mem_address];
    assign mem1_data_in = mem[mem1_address];

    oam_dma_arbiter dut (
        .core_clk         (core_clk),
        .reset            (reset),
        .cpu_address_bus  (cpu_address_bus),
        .cpu_data_bus_out (cpu_data_bus_out),
        .cpu_mem_we       (cpu_mem_we),
        .cpu_data_bus_in  (cpu_data_bus_in),
        .mem_address      (mem_address),
        .mem_data_out     (mem_data_out),
        .mem_we           (mem_we),
        .mem_data_in      (mem_data_in),
        .oam_address      (oam_address),
        .oam_data         (oam_data),
        .oam_we           (oam_we),
        .dma_active       (dma_active)
    );

    oam_dma_arbiter #(
        .DMA_LEN     (1),
        .START_DELAY (0)
    ) dut_short (
        .core_clk         (core_clk),
        .reset            (reset),
        .cpu_address_bus  (cpu1_address),
        .cpu_data_bus_out (cpu1_data),
        .cpu_mem_we       (cpu1_we),
        .cpu_data_bus_in  (cpu1_data_bus_in),
        .mem_address      (mem1_address),
        .mem_data_out     (mem1_data_out),
        .mem_we           (mem1_we),
        .mem_data_in      (mem1_data_in),
        .oam_address      (oam1_address),
        .oam_data         (oam1_data),
        .oam_we           (oam1_we),
        .dma_active       (dma1_active)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a[15:8] == 8'hC1) return a[7:0] ^ 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h33;
    endfunction

    // Mid-cycle sampling: memory decoder writes, active-cycle count, OAM scoreboard.
    task automatic monitor();
        logic [15:0] exp;
        if (mem_we === 1'b1) mem[mem_address] = mem_data_out;
        if (dma_active === 1'b1) active_cnt++;
        if (oam_we !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL oam_unexpected: got addr=%0d data=%02h we=%b, no write expected",
                         oam_address, oam_data, oam_we);
            end else begin
                exp = sb.pop_front();
                if ({oam_address, oam_data} !== exp) begin
                    errors++;
                    $display("FAIL oam_write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                             oam_address, oam_data, exp[15:8], exp[7:0]);
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge core_clk);
            monitor();
            @(posedge core_clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_address_bus  = a;
        cpu_data_bus_out = d;
        cpu_mem_we       = 1'b1;
        step(1);
        cpu_mem_we       = 1'b0;
        cpu_address_bus  = 16'h0000;
        #1;
    endtask

    task automatic push_page(input logic [7:0] page, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            sb.push_back({8'(k), init_val({page, 8'(k)})});
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (dma_active !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (dma_active !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: dma_active=%b after %0d cycles, expected 0", name,
                     dma_active, budget);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d OAM writes missing, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_address_bus = 16'h0000; cpu_data_bus_out = 8'h00; cpu_mem_we = 1'b0;
        cpu1_address = 16'h0000; cpu1_data = 8'h00; cpu1_we = 1'b0;
        step(3);
        reset = 1'b0;
        cpu_address_bus = 16'hFF46;
        #1;
        checks++;
        if ({dma_active, oam_we, oam_address, oam_data} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got active=%b we=%b addr=%02h data=%02h, expected zeros",
                     dma_active, oam_we, oam_address, oam_data);
        end
        checks++;
        if (cpu_data_bus_in !== 8'h00) begin
            errors++;
            $display("FAIL reset_dma_reg: got %02h, expected 00", cpu_data_bus_in);
        end
        checks++;
        if ({dma1_active, oam1_we} !== 2'b00) begin
            errors++;
            $display("FAIL reset_short: got active=%b we=%b, expected 0 0", dma1_active, oam1_we);
        end
        cpu_address_bus = 16'hC000; cpu_data_bus_out = 8'h55; cpu_mem_we = 1'b1;
        cpu1_address = 16'h4321; cpu1_data = 8'hA7;
        #1;
        checks++;
        if ({mem_address, mem_data_out, mem_we} !== {16'hC000, 8'h55, 1'b1}) begin
            errors++;
            $display("FAIL idle_passthru: got %04h/%02h/%b, expected C000/55/1", mem_address,
                     mem_data_out, mem_we);
        end
        checks++;
        if ({mem1_address, mem1_data_out} !== {16'h4321, 8'hA7}) begin
            errors++;
            $display("FAIL idle_passthru_short: got %04h/%02h, expected 4321/A7", mem1_address,
                     mem1_data_out);
        end
        cpu_mem_we = 1'b0;
        cpu_address_bus = 16'h0000;
        #1;
    endtask

    task automatic test_short();
        cpu1_address = 16'hFF46; cpu1_data = 8'hC1; cpu1_we = 1'b1;
        #1;
        checks++;
        if (mem1_we !== 1'b0) begin
            errors++;
            $display("FAIL short_reg_not_forwarded: got mem_we=%b, expected 0", mem1_we);
        end
        step(1);
        cpu1_we = 1'b0;
        cpu1_address = 16'h1234;
        #1;
        checks++;
        if ({mem1_address, oam1_we, dma1_active} !== {16'hC100, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL short_read: got addr=%04h we=%b active=%b, expected C100 0 1",
                     mem1_address, oam1_we, dma1_active);
        end
        step(1);
        checks++;
        if ({oam1_we, oam1_address, oam1_data, dma1_active} !== {1'b1, 8'h00, 8'h5A, 1'b1}) begin
            errors++;
            $display("FAIL short_write: got we=%b addr=%02h data=%02h active=%b, expected 1 00 5A 1",
                     oam1_we, oam1_address, oam1_data, dma1_active);
        end
        step(1);
        cpu1_address = 16'hFF46;
        #1;
        checks++;
        if ({dma1_active, oam1_we, cpu1_data_bus_in} !== {1'b0, 1'b0, 8'hC1}) begin
            errors++;
            $display("FAIL short_done: got active=%b we=%b reg=%02h, expected 0 0 C1",
                     dma1_active, oam1_we, cpu1_data_bus_in);
        end
        cpu1_address = 16'h0000;
    endtask

    task automatic test_transfer();
        push_page(8'hC1, 0, 159);
        active_cnt = 0;
        cpu_address_bus = 16'hFF46; cpu_data_bus_out = 8'hC1; cpu_mem_we = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reg_not_forwarded: got mem_we=%b, expected 0", mem_we);
        end
        step(1);
        // Cycle N+1 (START): fenced read and write of 8000
        cpu_address_bus = 16'h8000; cpu_mem_we = 1'b0;
        #1;
        checks++;
        if (cpu_data_bus_in !== 8'hFF) begin
            errors++;
            $display("FAIL fenced_read: got %02h, expected FF", cpu_data_bus_in);
        end
        cpu_data_bus_out = 8'h12; cpu_mem_we = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fenced_write: got mem_we=%b, expected 0", mem_we);
        end
        step(1);
        // Cycle N+2 (READ of byte 0)
        cpu_mem_we = 1'b0; cpu_address_bus = 16'hFF46;
        #1;
        checks++;
        if (cpu_data_bus_in !== 8'hC1) begin
            errors++;
            $display("FAIL reg_read_active: got %02h, expected C1", cpu_data_bus_in);
        end
        step(1);
        // Cycle N+3 (WRITE of byte 0): HRAM write
        cpu_address_bus = 16'hFF90; cpu_data_bus_out = 8'h3C; cpu_mem_we = 1'b1;
        #1;
        checks++;
        if ({mem_address, mem_data_out, mem_we} !== {16'hFF90, 8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL hram_write: got %04h/%02h/%b, expected FF90/3C/1", mem_address,
                     mem_data_out, mem_we);
        end
        step(1);
        cpu_mem_we = 1'b0; cpu_address_bus = 16'h0000;
        step(1);
        // Cycle N+5 (WRITE of byte 1): HRAM read
        cpu_address_bus = 16'hFF90;
        #1;
        checks++;
        if (cpu_data_bus_in !== 8'h3C) begin
            errors++;
            $display("FAIL hram_read: got %02h, expected 3C", cpu_data_bus_in);
        end
        cpu_address_bus = 16'h0000;
        wait_idle(400, "transfer");
        check_drained("transfer");
        checks++;
        if (active_cnt != 321) begin
            errors++;
            $display("FAIL transfer_active_cycles: got %0d, expected 321", active_cnt);
        end
        checks++;
        if (mem[16'h8000] !== init_val(16'h8000)) begin
            errors++;
            $display("FAIL fenced_write_mem: got %02h, expected %02h", mem[16'h8000],
                     init_val(16'h8000));
        end
        cpu_address_bus = 16'hFF46;
        #1;
        checks++;
        if (cpu_data_bus_in !== 8'hC1) begin
            errors++;
            $display("FAIL reg_read_idle: got %02h, expected C1", cpu_data_bus_in);
        end
        cpu_address_bus = 16'h0000;
    endtask

    task automatic test_restart();
        push_page(8'hC1, 0, 50);
        push_page(8'hD0, 0, 159);
        active_cnt = 0;
        cpu_write(16'hFF46, 8'hC1);
        step(102);
        // Cycle N+103: WRITE of byte 50
        checks++;
        if ({oam_we, oam_address, oam_data} !== {1'b1, 8'd50, init_val(16'hC132)}) begin
            errors++;
            $display("FAIL restart_byte50: got we=%b addr=%0d data=%02h, expected 1 50 %02h",
                     oam_we, oam_address, oam_data, init_val(16'hC132));
        end
        cpu_write(16'hFF46, 8'hD0);
        wait_idle(400, "restart");
        check_drained("restart");
        checks++;
        if (active_cnt != 424) begin
            errors++;
            $display("FAIL restart_active_cycles: got %0d, expected 424", active_cnt);
        end
    endtask

    task automatic test_wrap_source();
        push_page(8'hDE, 0, 159);
        cpu_write(16'hFF46, 8'hFE);
        wait_idle(400, "wrap");
        check_drained("wrap");
        cpu_address_bus = 16'hFF46;
        #1;
        checks++;
        if (cpu_data_bus_in !== 8'hFE) begin
            errors++;
            $display("FAIL wrap_reg: got %02h, expected FE", cpu_data_bus_in);
        end
        cpu_address_bus = 16'h0000;
    endtask

    task automatic test_reset_abort();
        push_page(8'hC1, 0, 79);
        cpu_write(16'hFF46, 8'hC1);
        step(161);
        // Cycle N+162: READ of byte 80
        reset = 1'b1;
        step(1);
        cpu_address_bus = 16'hFF46;
        #1;
        checks++;
        if ({oam_we, dma_active, cpu_data_bus_in} !== {1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL abort_state: got we=%b active=%b reg=%02h, expected 0 0 00", oam_we,
                     dma_active, cpu_data_bus_in);
        end
        cpu_address_bus = 16'h0000;
        step(2);
        reset = 1'b0;
        step(3);
        check_drained("abort");
        push_page(8'hD0, 0, 159);
        active_cnt = 0;
        cpu_write(16'hFF46, 8'hD0);
        wait_idle(400, "after_abort");
        check_drained("after_abort");
        checks++;
        if (active_cnt != 321) begin
            errors++;
            $display("FAIL after_abort_active_cycles: got %0d, expected 321", active_cnt);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = init_val(16'(a));
        mem[16'hFF90] = 8'h00;
        test_reset();
        test_short();
        test_transfer();
        test_restart();
        test_wrap_source();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
